// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit core: widths, fetch state encoding,
// opcode and ALU function fields.
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int PC_W    = 4;

  // Fetch FSM encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_ROM = 2'd1;
  localparam logic [1:0] RUN_SW  = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  // Opcode field, instr[7:6]
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] STORE = 2'b01;
  localparam logic [1:0] MOVE  = 2'b10;
  localparam logic [1:0] ALU   = 2'b11;

  // ALU function field, instr[1:0]
  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2;
  localparam logic [1:0] NOT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/prog_rom.sv
// Combinational program store: four programs of 2**PC_W words each,
// indexed by {romSel, addr}.
`default_nettype none

module prog_rom #(
  parameter int INSTR_W = 8,
  parameter int PC_W    = 4
) (
  input  logic [1:0]         romSel,
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] word
);
  import cpu_pkg::*;

  logic [3:0] a;
  logic [7:0] w;

  assign a = 4'(addr);

  // Program 0 is the core self-test; 1-3 are address-derived patterns.
  always_comb begin
    w = 8'h00;
    case (romSel)
      2'd0: begin
        case (a)
          4'd0:    w = {LOAD,  2'd0, 4'd0};
          4'd1:    w = {LOAD,  2'd1, 4'd1};
          4'd2:    w = {LOAD,  2'd2, 4'd2};
          4'd3:    w = {LOAD,  2'd3, 4'd3};
          4'd4:    w = {STORE, 2'd0, 4'd0};
          4'd5:    w = {MOVE,  2'd0, 2'd1, 2'd0};
          4'd6:    w = {ALU,   2'd0, 2'd1, ADD};
          4'd7:    w = {ALU,   2'd1, 2'd2, SUB};
          4'd8:    w = {ALU,   2'd2, 2'd3, AND};
          4'd9:    w = {ALU,   2'd3, 2'd0, NOT};
          default: w = 8'h00;
        endcase
      end
      2'd1:    w = {4'hA, a};
      2'd2:    w = {a, 4'h5};
      default: w = ~{a, a};
    endcase
  end

  assign word = INSTR_W'(w);

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// Instruction source for the 4-bit core: streams a ROM program or
// front-panel switch words onto a valid/ready handshake.
`default_nettype none

module instr_fetch #(
  parameter int INSTR_W   = 8,
  parameter int PC_W      = 4,
  parameter int ROM_DEPTH = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               instSel,
  input  logic [1:0]         romSel,
  input  logic [INSTR_W-1:0] data,
  input  logic               load,
  input  logic               ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instrValid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic               overrun
);
  import cpu_pkg::*;

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(ROM_DEPTH - 1);

  logic [1:0]         state;
  logic [1:0]         romSelQ;
  logic               loadQ;
  logic [PC_W-1:0]    fetchAddr;
  logic [INSTR_W-1:0] romWord;
  logic               transfer;
  logic               canLoad;
  logic               loadEdge;

  assign transfer = instrValid && ready;
  assign canLoad  = !instrValid || transfer;
  assign loadEdge = load && !loadQ;

  prog_rom #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_rom (
    .romSel (romSelQ),
    .addr   (fetchAddr),
    .word   (romWord)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      romSelQ    <= 2'd0;
      loadQ      <= 1'b0;
      fetchAddr  <= '0;
      instr      <= '0;
      instrValid <= 1'b0;
      pc         <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      loadQ <= load;
      case (state)
        IDLE: begin
          romSelQ   <= romSel;
          fetchAddr <= '0;
          state     <= instSel ? RUN_ROM : RUN_SW;
        end
        RUN_ROM: begin
          // The terminal word is recognised on its transfer, so fetchAddr
          // parks at LAST_ADDR instead of wrapping.
          if (transfer && (pc == LAST_ADDR)) begin
            instrValid <= 1'b0;
            done       <= 1'b1;
            state      <= HALT;
          end else if (canLoad) begin
            instr      <= romWord;
            pc         <= fetchAddr;
            instrValid <= 1'b1;
            if (fetchAddr != LAST_ADDR) begin
              fetchAddr <= fetchAddr + PC_W'(1);
            end
          end
        end
        RUN_SW: begin
          if (loadEdge) begin
            if (canLoad) begin
              instr      <= data;
              instrValid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (transfer) begin
            instrValid <= 1'b0;
          end
        end
        HALT: begin
          instrValid <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transfer scoreboard, hold-stability
// check and directed scenarios with literal expectations.
`default_nettype none

module tb_instr_fetch;

  logic       clk;
  logic       clr;
  logic       instSel;
  logic [1:0] romSel;
  logic [7:0] data;
  logic       load;
  logic       ready;
  logic [7:0] instr;
  logic       instrValid;
  logic [3:0] pc;
  logic       done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Expected transfers in order, each {pc, instr}
  logic [11:0] exp_q[$];

  logic       hold_v = 1'b0;
  logic [7:0] hold_i;
  logic [3:0] hold_p;

  instr_fetch #(
    .INSTR_W   (8),
    .PC_W      (4),
    .ROM_DEPTH (16)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .instSel    (instSel),
    .romSel     (romSel),
    .data       (data),
    .load       (load),
    .ready      (ready),
    .instr      (instr),
    .instrValid (instrValid),
    .pc         (pc),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rom(input int p, input int a);
    logic [3:0] aa;
    aa = a[3:0];
    case (p)
      0: begin
        case (a)
          1: return 8'h11;
          2: return 8'h22;
          3: return 8'h33;
          4: return 8'h40;
          5: return 8'h84;
          6: return 8'hC4;
          7: return 8'hD9;
          8: return 8'hEE;
          9: return 8'hF3;
          default: return 8'h00;
        endcase
      end
      1: return {4'hA, aa};
      2: return {aa, 4'h5};
      default: return ~{aa, aa};
    endcase
  endfunction

  task automatic queue_prog(input int p);
    for (int a = 0; a < 16; a++) exp_q.push_back({4'(a), model_rom(p, a)});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Holds clr over two edges, releases it just after an edge.
  task automatic start(input logic is, input logic [1:0] rs, input logic rdy);
    clr = 1'b1;
    instSel = is;
    romSel = rs;
    ready = rdy;
    load = 1'b0;
    data = 8'h00;
    exp_q.delete();
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the next expected word, and a
  // stalled word must not change before it is taken.
  always @(negedge clk) begin
    if (clr) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {instrValid, pc, instr}, {1'b1, hold_p, hold_i});
      if (instrValid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_xfer", {pc, instr}, 12'hFFF);
        else chk("xfer", {pc, instr}, exp_q.pop_front());
      end
      hold_v = instrValid && !ready;
      hold_i = instr;
      hold_p = pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; instSel = 1'b1; romSel = 2'd0; data = 8'h00; load = 1'b0; ready = 1'b0;
    step();
    chk("reset_state", {instr, instrValid, pc, done, overrun}, 16'h0000);

    // ROM streaming, program 0
    start(1'b1, 2'd0, 1'b1);
    queue_prog(0);
    step();
    chk("first_edge_invalid", instrValid, 0);
    step();
    chk("first_word", {instrValid, pc, instr}, {1'b1, 4'd0, 8'h00});
    repeat (6) step();
    chk("word6_add", {instrValid, pc, instr}, {1'b1, 4'd6, 8'hC4});
    drain("stream_drain");
    chk("stream_end", {instrValid, done}, 2'b01);
    for (int i = 0; i < 10; i++) begin
      load = i[0];
      ready = i[1];
      romSel = i[1:0];
      step();
    end
    chk("halt_sticky", {instrValid, done, overrun}, 3'b010);

    // Backpressure with the word at pc=2 stalled
    start(1'b1, 2'd0, 1'b1);
    queue_prog(0);
    step();
    step();
    step();
    step();
    ready = 1'b0;
    chk("bp_stall_pc2", {instrValid, pc, instr}, {1'b1, 4'd2, 8'h22});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_frozen", {instrValid, pc, instr}, {1'b1, 4'd2, 8'h22});
    end
    ready = 1'b1;
    drain("bp_drain");
    chk("bp_done", done, 1);

    // Selection latched in IDLE; later changes ignored
    start(1'b1, 2'd2, 1'b1);
    queue_prog(2);
    step();
    romSel = 2'd1;
    instSel = 1'b0;
    step();
    chk("sel_first", {instrValid, pc, instr}, {1'b1, 4'd0, 8'h05});
    drain("sel_drain");
    chk("sel_done", done, 1);

    // Asynchronous reset while a word is stalled
    start(1'b1, 2'd3, 1'b0);
    step();
    step();
    chk("pre_clr_word", {instrValid, pc, instr}, {1'b1, 4'd0, 8'hFF});
    step();
    clr = 1'b1;
    #1;
    chk("async_clr", {instr, instrValid, pc, done, overrun}, 16'h0000);
    step();
    exp_q.delete();
    queue_prog(3);
    ready = 1'b1;
    clr = 1'b0;
    step();
    chk("post_clr_invalid", instrValid, 0);
    step();
    chk("post_clr_first", {instrValid, pc, instr}, {1'b1, 4'd0, 8'hFF});
    drain("post_clr_drain");

    // Switch mode, four loads
    start(1'b0, 2'd0, 1'b1);
    step();
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd0, 8'(i * 8'h11)});
    for (int i = 0; i < 4; i++) begin
      data = 8'(i * 8'h11);
      load = 1'b1;
      step();
      load = 1'b0;
      step();
    end
    step();
    chk("sw_all_taken", exp_q.size(), 0);
    chk("sw_flags", {instrValid, done, overrun, pc}, 7'b0000000);

    // Overrun: second edge while first word is stalled
    start(1'b0, 2'd0, 1'b0);
    step();
    step();
    data = 8'hD8;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    data = 8'hD9;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("ovr_held", {instrValid, overrun, instr}, {1'b1, 1'b1, 8'hD8});
    exp_q.push_back({4'd0, 8'hD8});
    ready = 1'b1;
    step();
    step();
    step();
    chk("ovr_one_xfer", exp_q.size(), 0);
    chk("ovr_final", {instrValid, overrun, done, instr}, {1'b0, 1'b1, 1'b0, 8'hD8});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction source stage directly upstream of the 4-bit core's decode/execute logic.
- Selects between the front-panel switch input and one of four on-chip ROM programs.
- Presents one 8-bit instruction at a time on a valid/ready handshake.
- In ROM mode, asserts done after the last program word is accepted; the board or bench then pulses clr to restart.

Parameters:
- INSTR_W, 8: instruction width.
- PC_W, 4: program counter width.
- ROM_DEPTH, 16: words per ROM program; must equal 2**PC_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- instSel  in  1  source select: 0 = switches, 1 = ROM. Sampled only in IDLE.
- romSel  in  2  ROM program select, 0-3. Sampled only in IDLE.
- data  in  INSTR_W  switch instruction word.
- load  in  1  switch load request, level from debounced button; rising edge = one instruction.
- ready  in  1  downstream core can accept an instruction this cycle.
- instr  out  INSTR_W  registered instruction.
- instrValid  out  1  instr holds an instruction not yet accepted.
- pc  out  PC_W  ROM address of the word currently on instr (0 in switch mode).
- done  out  1  ROM program complete; sticky until clr.
- overrun  out  1  a switch load edge was dropped; sticky until clr.

Behaviour:
- Reset (clr high, any time, including mid-transfer):
  - instr=0, instrValid=0, pc=0, done=0, overrun=0, state=IDLE, load-edge register=0.
  - Any pending instruction is discarded.
- Transfer rule: a transfer occurs on a rising edge where instrValid && ready.
  - While instrValid && !ready, instr and pc must hold stable.
- FSM:
  - IDLE: one cycle after clr deasserts. Latch instSel and romSel into internal registers, then go to RUN_ROM (instSel=1) or RUN_SW (instSel=0).
  - RUN_ROM: the output register loads rom[romSelLatched][fetchAddr] whenever (!instrValid || transfer).
    - First word is valid in the first cycle after IDLE: instrValid rises 2 clk edges after clr falls.
    - fetchAddr increments per load; back-to-back throughput is 1 instruction/cycle with ready held high.
    - pc always shows the address of the word on instr.
    - When the word at address ROM_DEPTH-1 is transferred: instrValid drops, done=1 in the same edge's result, go to HALT. No wrap to address 0.
  - RUN_SW:
    - load is registered once; edge = load && !loadQ.
    - On an edge with (!instrValid || transfer) in the same cycle: instr<=data, instrValid<=1.
    - On an edge while instrValid && !ready: the word is dropped and overrun<=1.
    - Without an edge, a transfer clears instrValid.
    - done is never asserted in switch mode; pc stays 0.
  - HALT: instrValid=0, done=1. Stays here until clr; all inputs are ignored.
- Changes on instSel or romSel after IDLE are ignored until the next clr.
- No arithmetic beyond the PC_W-bit increment. Terminal detection compares against ROM_DEPTH-1 before incrementing, so the increment never overflows.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W and PC_W.
  - Fetch state encoding: IDLE=2'd0, RUN_ROM=2'd1, RUN_SW=2'd2, HALT=2'd3.
  - Opcode field constants used by the core: LOAD=2'b00, STORE=2'b01, MOVE=2'b10, ALU=2'b11.
  - ALU function constants: ADD=0, SUB=1, AND=2, NOT=3.
- Sub-module prog_rom: combinational read of 4 programs × ROM_DEPTH words, indexed by {romSel, addr}.
  - Program 0 is the core self-test: LOAD R0..R3 0..3, STORE, MOVE, ADD/SUB/AND/NOT sequence, remaining words 8'h00.
  - Contents are defined in prog_rom only; the bench reads them through hierarchical reference or its own copy of the table.

Test Plan:
- Reset mid-stream: clr pulses while instrValid=1 with ready=0 -> outputs go to zero immediately (asynchronously); after release, the first word reappears from address 0.
- ROM streaming: instSel=1, romSel=0, ready=1, release clr -> instrValid=1 on the second edge with pc=0 and instr=rom[0][0]. Then one word/cycle, pc 0..15. done=1 and instrValid=0 right after word 15 transfers; still done=1 after 10 more cycles.
- Backpressure: ROM mode, ready low for cycles 3-5 -> instr and pc are frozen at pc=2 for those cycles. No word is skipped or repeated (bench compares the full 16-word sequence).
- Select latch: romSel=2 at reset, changed to 1 after IDLE -> all 16 words match rom[2].
- Switch mode: instSel=0, ready=1, load toggled every 2 cycles with data 8'h00, 8'h11, 8'h22, 8'h33 -> exactly four transfers in order; overrun=0; done=0.
- Overrun: switch mode, ready=0, two load edges with data 8'hD8 then 8'hD9 -> instr=8'hD8 stays valid and overrun=1. After ready=1, one transfer of 8'hD8 only.
